carregador_pedidos_fila: RTL and testbench

- Upstream loader for the SmartCargo request queue RAM (sync_ram_16x4_mod).
- Accepts one transport request (object type, origin floor, destination floor) from the panel/control unit and validates it against queue occupancy.
- Writes each accepted request into the queue tail as two consecutive weT entries: an origin entry, then a destination entry.
- Tracks queue occupancy, including pops (shift) issued by the downstream controller.

---
 rtl/carregador_pedidos_fila.sv | 151 +++++++++++++++
 tb/tb_carregador_pedidos_fila.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_pedidos_fila.sv
// carregador_pedidos_fila
// Upstream loader for the SmartCargo request queue RAM. It accepts one
// transport request at a time and validates it against queue occupancy.
// Each accepted request is written to the queue tail as two consecutive
// entries: the origin entry first, then the destination entry. The block
// also tracks occupancy, including head pops issued by the downstream
// controller.

module carregador_pedidos_fila #(
    parameter int PROFUNDIDADE = 16,
    parameter int LARG_OCUP    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 novo_pedido,
    input  logic [1:0]           tipo,
    input  logic [1:0]           origem,
    input  logic [1:0]           destino,
    input  logic                 shift_fila,
    input  logic                 limpar,
    output logic                 weT,
    output logic                 in_eh_origem,
    output logic [1:0]           in_tipo_objeto,
    output logic [1:0]           in_origem_objeto,
    output logic [1:0]           in_destino_objeto,
    output logic                 clear,
    output logic                 pronto,
    output logic                 pedido_aceito,
    output logic                 pedido_rejeitado,
    output logic [LARG_OCUP-1:0] ocupacao,
    output logic                 fila_vazia,
    output logic                 fila_cheia
);

    // Controller states. The encoding is kept explicit so that it can be
    // compared directly with older gate-level dumps.
    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] VALIDA      = 3'd1;
    localparam logic [2:0] ESC_ORIGEM  = 3'd2;
    localparam logic [2:0] ESC_DESTINO = 3'd3;
    localparam logic [2:0] CONCLUI     = 3'd4;
    localparam logic [2:0] REJEITA     = 3'd5;

    // A request needs two free entries, so any count above DEPTH-2 is too full.
    localparam logic [LARG_OCUP-1:0] LIMITE_ACEITE = LARG_OCUP'(PROFUNDIDADE - 2);
    localparam logic [LARG_OCUP-1:0] OCUP_CHEIA    = LARG_OCUP'(PROFUNDIDADE);
    localparam logic [LARG_OCUP-1:0] OCUP_UM       = LARG_OCUP'(1);

    logic [2:0]           estado_q, estado_d;
    logic [LARG_OCUP-1:0] ocup_q, ocup_d;
    logic [1:0]           tipo_q, tipo_d;
    logic [1:0]           origem_q, origem_d;
    logic [1:0]           destino_q, destino_d;
    logic                 clear_q;
    logic                 latch_pedido;

    // Next-state logic: one state per cycle, with limpar overriding everything.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through the block leaves a value unassigned, and no latch is inferred.
        estado_d     = estado_q;
        latch_pedido = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (novo_pedido) begin
                    latch_pedido = 1'b1;
                    estado_d     = VALIDA;
                end
            end
            VALIDA: begin
                // The registered count is used here. A pop in the same cycle
                // is not credited.
                if ((origem_q == destino_q) || (ocup_q > LIMITE_ACEITE))
                    estado_d = REJEITA;
                else
                    estado_d = ESC_ORIGEM;
            end
            ESC_ORIGEM:  estado_d = ESC_DESTINO;
            ESC_DESTINO: estado_d = CONCLUI;
            CONCLUI:     estado_d = OCIOSO;
            REJEITA:     estado_d = OCIOSO;
            default:     estado_d = OCIOSO;
        endcase
        if (limpar) begin
            estado_d     = OCIOSO;
            latch_pedido = 1'b0;
        end
    end

    // Field capture: the request fields are loaded only when a strobe is accepted.
    always_comb begin
        tipo_d    = latch_pedido ? tipo    : tipo_q;
        origem_d  = latch_pedido ? origem  : origem_q;
        destino_d = latch_pedido ? destino : destino_q;
    end

    // Occupancy: a tail write adds one and a head pop removes one; when both
    // happen they cancel. The count never wraps in either direction.
    always_comb begin
        ocup_d = ocup_q;
        if (limpar) begin
            ocup_d = '0;
        end else if (weT && !shift_fila) begin
            if (ocup_q != OCUP_CHEIA)
                ocup_d = ocup_q + OCUP_UM;
        end else if (!weT && shift_fila) begin
            if (ocup_q != '0)
                ocup_d = ocup_q - OCUP_UM;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: a synchronous reset clears every register, including the field
            // registers, so the in_* outputs are known from the first cycle.
            estado_q  <= OCIOSO;
            ocup_q    <= '0;
            tipo_q    <= '0;
            origem_q  <= '0;
            destino_q <= '0;
            clear_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together
            // from values sampled before the edge.
            estado_q  <= estado_d;
            ocup_q    <= ocup_d;
            tipo_q    <= tipo_d;
            origem_q  <= origem_d;
            destino_q <= destino_d;
            clear_q   <= limpar;
        end
    end

    // Outputs are decoded combinationally from the state and the registers.
    always_comb begin
        weT               = (estado_q == ESC_ORIGEM) || (estado_q == ESC_DESTINO);
        in_eh_origem      = (estado_q == ESC_ORIGEM);
        in_tipo_objeto    = tipo_q;
        in_origem_objeto  = origem_q;
        in_destino_objeto = destino_q;
        clear             = clear_q;
        pronto            = (estado_q == OCIOSO);
        pedido_aceito     = (estado_q == CONCLUI);
        pedido_rejeitado  = (estado_q == REJEITA);
        ocupacao          = ocup_q;
        fila_vazia        = (ocup_q == '0);
        fila_cheia        = (ocup_q == OCUP_CHEIA);
    end

endmodule

// File: tb/tb_carregador_pedidos_fila.sv
// tb_carregador_pedidos_fila
// Directed bench for the request-queue loader. A table of requests takes the
// queue from empty to full; hand-written sequences cover pops, flushes,
// strobes while busy and a reset in the middle of a request.

module tb_carregador_pedidos_fila;

    logic       clk;
    logic       reset_n;
    logic       novo_pedido;
    logic [1:0] tipo, origem, destino;
    logic       shift_fila;
    logic       limpar;
    logic       weT, in_eh_origem;
    logic [1:0] in_tipo_objeto, in_origem_objeto, in_destino_objeto;
    logic       clear, pronto, pedido_aceito, pedido_rejeitado;
    logic [4:0] ocupacao;
    logic       fila_vazia, fila_cheia;

    int tests = 0;
    int fails = 0;

    carregador_pedidos_fila #(.PROFUNDIDADE(16), .LARG_OCUP(5)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .novo_pedido      (novo_pedido),
        .tipo             (tipo),
        .origem           (origem),
        .destino          (destino),
        .shift_fila       (shift_fila),
        .limpar           (limpar),
        .weT              (weT),
        .in_eh_origem     (in_eh_origem),
        .in_tipo_objeto   (in_tipo_objeto),
        .in_origem_objeto (in_origem_objeto),
        .in_destino_objeto(in_destino_objeto),
        .clear            (clear),
        .pronto           (pronto),
        .pedido_aceito    (pedido_aceito),
        .pedido_rejeitado (pedido_rejeitado),
        .ocupacao         (ocupacao),
        .fila_vazia       (fila_vazia),
        .fila_cheia       (fila_cheia)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The occupancy count must never exceed the depth.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && ocupacao > 5'd16) begin
            fails++;
            $display("FAIL ocup_bound: got %0d required <= 16", ocupacao);
        end
    end

    typedef struct {
        logic [1:0] tipo;
        logic [1:0] origem;
        logic [1:0] destino;
        logic       aceita;
        logic [4:0] ocup;
        logic       cheia;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where inputs are driven and outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ocup"},  32'(ocupacao), 32'd0);
        check({tag, "_weT"},   32'(weT), 32'd0);
        check({tag, "_clear"}, 32'(clear), 32'd0);
        check({tag, "_ac"},    32'(pedido_aceito), 32'd0);
        check({tag, "_rj"},    32'(pedido_rejeitado), 32'd0);
        check({tag, "_pronto"},32'(pronto), 32'd1);
        check({tag, "_vazia"}, 32'(fila_vazia), 32'd1);
        check({tag, "_cheia"}, 32'(fila_cheia), 32'd0);
        check({tag, "_fields"},
              32'({in_tipo_objeto, in_origem_objeto, in_destino_objeto}), 32'd0);
    endtask

    // Issue one request with its strobe in cycle 0, then watch cycles 1..7.
    // shift_at and strobe2_at (-1 disables them) add a pop or a second strobe
    // in that cycle. The weT, accept and reject timing is compared with the
    // cycle pattern the loader must produce.
    task automatic run_req(input string name, input logic [1:0] t, input logic [1:0] o,
                           input logic [1:0] d, input logic aceita, input logic [4:0] ocup_fim,
                           input int shift_at, input int strobe2_at);
        logic [7:0] w_bits, e_bits, a_bits, r_bits;
        w_bits = '0; e_bits = '0; a_bits = '0; r_bits = '0;
        tipo = t; origem = o; destino = d;
        novo_pedido = 1'b1;
        shift_fila  = (shift_at == 0);
        check({name, "_pronto0"}, 32'(pronto), 32'd1);
        for (int c = 1; c < 8; c++) begin
            step();
            novo_pedido = (c == strobe2_at);
            shift_fila  = (c == shift_at);
            w_bits[c] = weT;
            e_bits[c] = weT & in_eh_origem;
            a_bits[c] = pedido_aceito;
            r_bits[c] = pedido_rejeitado;
            if (weT)
                check({name, "_fields"},
                      32'({in_tipo_objeto, in_origem_objeto, in_destino_objeto}),
                      32'({t, o, d}));
        end
        novo_pedido = 1'b0;
        shift_fila  = 1'b0;
        check({name, "_weT"}, 32'(w_bits), aceita ? 32'h0c : 32'h00);
        check({name, "_eh"},  32'(e_bits), aceita ? 32'h04 : 32'h00);
        check({name, "_ac"},  32'(a_bits), aceita ? 32'h10 : 32'h00);
        check({name, "_rj"},  32'(r_bits), aceita ? 32'h00 : 32'h04);
        check({name, "_ocup"}, 32'(ocupacao), 32'(ocup_fim));
    endtask

    initial begin
        reset_n = 1'b0; novo_pedido = 1'b0; tipo = '0; origem = '0; destino = '0;
        shift_fila = 1'b0; limpar = 1'b0;

        // Hold reset for two cycles.
        step(); step();
        check_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // Fill from empty to full and one beyond. Expected values are hand-computed.
        vecs[0] = '{2'b10, 2'b01, 2'b11, 1'b1, 5'd2,  1'b0};
        vecs[1] = '{2'b01, 2'b10, 2'b10, 1'b0, 5'd2,  1'b0};
        vecs[2] = '{2'b00, 2'b00, 2'b01, 1'b1, 5'd4,  1'b0};
        vecs[3] = '{2'b11, 2'b11, 2'b00, 1'b1, 5'd6,  1'b0};
        vecs[4] = '{2'b01, 2'b10, 2'b00, 1'b1, 5'd8,  1'b0};
        vecs[5] = '{2'b10, 2'b01, 2'b10, 1'b1, 5'd10, 1'b0};
        vecs[6] = '{2'b00, 2'b11, 2'b01, 1'b1, 5'd12, 1'b0};
        vecs[7] = '{2'b11, 2'b00, 2'b11, 1'b1, 5'd14, 1'b0};
        vecs[8] = '{2'b01, 2'b01, 2'b00, 1'b1, 5'd16, 1'b1};
        vecs[9] = '{2'b10, 2'b00, 2'b10, 1'b0, 5'd16, 1'b1};
        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].tipo, vecs[i].origem, vecs[i].destino,
                    vecs[i].aceita, vecs[i].ocup, -1, -1);
            check($sformatf("vec%0d_cheia", i), 32'(fila_cheia), 32'(vecs[i].cheia));
        end

        // One pop leaves 15 entries, which is still too full for a request.
        shift_fila = 1'b1; step(); shift_fila = 1'b0;
        check("pop_to15", 32'(ocupacao), 32'd15);
        run_req("req_at15", 2'b01, 2'b00, 2'b11, 1'b0, 5'd15, -1, -1);

        // A flush while idle: clear follows limpar by one cycle.
        limpar = 1'b1; step(); limpar = 1'b0;
        check("flush_clear", 32'(clear), 32'd1);
        check("flush_ocup",  32'(ocupacao), 32'd0);
        check("flush_vazia", 32'(fila_vazia), 32'd1);
        step();
        check("flush_clear_off", 32'(clear), 32'd0);

        // A pop at zero occupancy is ignored.
        shift_fila = 1'b1; step(); shift_fila = 1'b0;
        check("pop_at0", 32'(ocupacao), 32'd0);

        // A pop during ESC_ORIGEM starting from 4 entries gives 4 + 2 - 1 = 5.
        run_req("pre_a", 2'b00, 2'b00, 2'b10, 1'b1, 5'd2, -1, -1);
        run_req("pre_b", 2'b01, 2'b11, 2'b10, 1'b1, 5'd4, -1, -1);
        run_req("pop_wr", 2'b10, 2'b10, 2'b01, 1'b1, 5'd5, 2, -1);

        // A second strobe during ESC_DESTINO is ignored and is not queued.
        run_req("busy_strobe", 2'b11, 2'b01, 2'b00, 1'b1, 5'd7, -1, 3);

        // A flush during ESC_ORIGEM drops the request without an accept pulse.
        tipo = 2'b01; origem = 2'b00; destino = 2'b11;
        novo_pedido = 1'b1; step(); novo_pedido = 1'b0;
        step();
        check("flushmid_weT", 32'(weT), 32'd1);
        limpar = 1'b1; step(); limpar = 1'b0;
        check("flushmid_clear",  32'(clear), 32'd1);
        check("flushmid_ocup",   32'(ocupacao), 32'd0);
        check("flushmid_pronto", 32'(pronto), 32'd1);
        begin
            logic seen_ac;
            seen_ac = 1'b0;
            for (int c = 0; c < 4; c++) begin
                seen_ac |= pedido_aceito | weT;
                step();
            end
            check("flushmid_no_ac", 32'(seen_ac), 32'd0);
        end

        // A reset while in VALIDA aborts the request before any write.
        tipo = 2'b11; origem = 2'b10; destino = 2'b01;
        novo_pedido = 1'b1; step(); novo_pedido = 1'b0;
        reset_n = 1'b0; step();
        check_reset_vals("rstmid");
        reset_n = 1'b1;
        begin
            logic seen_w;
            seen_w = 1'b0;
            for (int c = 0; c < 5; c++) begin
                step();
                seen_w |= weT | pedido_aceito | pedido_rejeitado;
            end
            check("rstmid_no_weT", 32'(seen_w), 32'd0);
            check("rstmid_ocup", 32'(ocupacao), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety limit on the total simulation time.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
